// File: rtl/alu_pkg.sv
// Shared ALU definitions: the sequencer state encoding, the default datapath
// width, and the bit positions the ALU flag register uses for the adder flags.
package alu_pkg;

   localparam int ALU_WIDTH = 8;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_FIN  = 2'd2;

   localparam int FLAG_ZERO  = 0;
   localparam int FLAG_CARRY = 1;
   localparam int FLAG_OVF   = 2;

endpackage

// File: rtl/serial_adder_digit_adder.sv
// digit_adder: combinational DIGIT-bit full adder, one slice of the serial sum.
module digit_adder #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] sum,
   output logic             cout
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle WIDTH-bit adder, DIGIT bits per clock, behind a
// START/BUSY/DONE handshake. Build macro SERIAL_ADDER_FLAGS_EN enables the
// COUT/OVF/ZERO flag logic; without it those outputs are tied low.
//
// state | meaning
// IDLE  | waiting for START
// RUN   | N digit steps (cnt 0..N-1), then one settle cycle at cnt==N
// FIN   | DONE pulse; START here starts the next addition immediately
module serial_adder
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int DIGIT = 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RES,
   output logic             COUT,
   output logic             OVF,
   output logic             ZERO
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = $clog2(N + 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_q;
   logic             carry;
   logic             busy_q;

   logic [DIGIT-1:0] dsum;
   logic             dcout;
   logic [WIDTH-1:0] sum_top;
   logic             accept;
   logic             step;
   logic             last;

   digit_adder #(.DIGIT(DIGIT)) u_digit_adder (
      .a    (a_sh[DIGIT-1:0]),
      .b    (b_sh[DIGIT-1:0]),
      .cin  (carry),
      .sum  (dsum),
      .cout (dcout)
   );

   assign accept  = START && ((state == ST_IDLE) || (state == ST_FIN));
   assign step    = (state == ST_RUN) && (cnt != CW'(N));
   assign last    = (state == ST_RUN) && (cnt == CW'(N));
   assign sum_top = WIDTH'(dsum) << (WIDTH - DIGIT);

   // Sequencer: IDLE -> RUN -> FIN, with back-to-back restart from FIN.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (START) state <= ST_RUN;
            ST_RUN:  if (last) state <= ST_FIN;
            ST_FIN:  state <= START ? ST_RUN : ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Operand shift registers, carry, digit counter and result accumulation.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         a_sh  <= '0;
         b_sh  <= '0;
         res_q <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else if (accept) begin
         a_sh  <= A;
         b_sh  <= B;
         res_q <= '0;
         carry <= CIN;
         cnt   <= '0;
      end else if (step) begin
         a_sh  <= a_sh >> DIGIT;
         b_sh  <= b_sh >> DIGIT;
         res_q <= (res_q >> DIGIT) | sum_top;
         carry <= dcout;
         cnt   <= cnt + CW'(1);
      end
   end

   // BUSY covers exactly the cycles following a digit step.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) busy_q <= 1'b0;
      else     busy_q <= step;
   end

   assign BUSY = busy_q;
   assign DONE = (state == ST_FIN);
   assign RES  = res_q;

`ifdef SERIAL_ADDER_FLAGS_EN
   logic a_msb;
   logic b_msb;
   logic cout_q;
   logic ovf_q;
   logic zero_q;

   // Flags are captured on the settle cycle and cleared by the next accept.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (accept) begin
         a_msb  <= A[WIDTH-1];
         b_msb  <= B[WIDTH-1];
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (last) begin
         cout_q <= carry;
         ovf_q  <= (a_msb == b_msb) && (res_q[WIDTH-1] != a_msb);
         zero_q <= (res_q == '0);
      end
   end

   assign COUT = cout_q;
   assign OVF  = ovf_q;
   assign ZERO = zero_q;
`else
   assign COUT = 1'b0;
   assign OVF  = 1'b0;
   assign ZERO = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: DIGIT=1 handshake/arithmetic cases plus
// DIGIT=4 and DIGIT=8 instances checked against a reference sum.
module tb_serial_adder;

`ifdef SERIAL_ADDER_FLAGS_EN
   localparam bit FL = 1'b1;
`else
   localparam bit FL = 1'b0;
`endif

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] A = '0;
   logic [7:0] B = '0;
   logic       CIN = 1'b0;
   logic       start1 = 1'b0, start4 = 1'b0, start8 = 1'b0;

   logic       busy1, done1, cout1, ovf1, zero1;
   logic       busy4, done4, cout4, ovf4, zero4;
   logic       busy8, done8, cout8, ovf8, zero8;
   logic [7:0] res1, res4, res8;

   int n_checks = 0;
   int n_fail   = 0;
   int sel      = 1;

   logic       busy_m, done_m, cout_m, ovf_m, zero_m;
   logic [7:0] res_m;

   always #5 CLK = ~CLK;

   serial_adder #(.WIDTH(8), .DIGIT(1)) dut1 (
      .CLK(CLK), .RST(RST), .START(start1), .A(A), .B(B), .CIN(CIN),
      .BUSY(busy1), .DONE(done1), .RES(res1), .COUT(cout1), .OVF(ovf1), .ZERO(zero1));
   serial_adder #(.WIDTH(8), .DIGIT(4)) dut4 (
      .CLK(CLK), .RST(RST), .START(start4), .A(A), .B(B), .CIN(CIN),
      .BUSY(busy4), .DONE(done4), .RES(res4), .COUT(cout4), .OVF(ovf4), .ZERO(zero4));
   serial_adder #(.WIDTH(8), .DIGIT(8)) dut8 (
      .CLK(CLK), .RST(RST), .START(start8), .A(A), .B(B), .CIN(CIN),
      .BUSY(busy8), .DONE(done8), .RES(res8), .COUT(cout8), .OVF(ovf8), .ZERO(zero8));

   always_comb begin
      busy_m = busy1; done_m = done1; res_m = res1;
      cout_m = cout1; ovf_m = ovf1; zero_m = zero1;
      if (sel == 4) begin
         busy_m = busy4; done_m = done4; res_m = res4;
         cout_m = cout4; ovf_m = ovf4; zero_m = zero4;
      end else if (sel == 8) begin
         busy_m = busy8; done_m = done8; res_m = res8;
         cout_m = cout8; ovf_m = ovf8; zero_m = zero8;
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic launch(input int s, input logic [7:0] a, input logic [7:0] b, input logic c);
      sel = s;
      A = a; B = b; CIN = c;
      start1 = (s == 1); start4 = (s == 4); start8 = (s == 8);
      tick();
      start1 = 1'b0; start4 = 1'b0; start8 = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int busy_cnt);
      lat = -1;
      busy_cnt = 0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (done_m) begin
            lat = i;
            break;
         end
         if (busy_m) busy_cnt++;
      end
   endtask

   task automatic check_result(input string tag, input logic [7:0] a, input logic [7:0] b,
                               input logic c, input int lat, input int exp_lat);
      logic [8:0] full;
      logic       v;
      full = {1'b0, a} + {1'b0, b} + {8'd0, c};
      v    = (a[7] == b[7]) && (full[7] != a[7]);
      chk({tag, "_lat"},  lat, exp_lat);
      chk({tag, "_res"},  int'(res_m), int'(full[7:0]));
      chk({tag, "_cout"}, int'(cout_m), int'(full[8] & FL));
      chk({tag, "_ovf"},  int'(ovf_m),  int'(v & FL));
      chk({tag, "_zero"}, int'(zero_m), int'((full[7:0] == 8'h00) & FL));
   endtask

   initial begin
      int lat, bc;
      logic [7:0] ra, rb;
      logic rc;

      tick(); tick();
      chk("rst_busy", int'(busy1), 0);
      chk("rst_done", int'(done1), 0);
      chk("rst_res",  int'(res1),  0);
      chk("rst_flags", int'({cout1, ovf1, zero1}), 0);
      RST = 1'b0;
      tick();

      // basic add
      launch(1, 8'h12, 8'h34, 1'b0);
      chk("basic_busy_edge0", int'(busy1), 0);
      wait_done(lat, bc);
      chk("basic_busy_cycles", bc, 8);
      chk("basic_res_hex", int'(res1), 8'h46);
      check_result("basic", 8'h12, 8'h34, 1'b0, lat, 9);
      tick();
      chk("basic_done_pulse", int'(done1), 0);
      chk("basic_res_hold", int'(res1), 8'h46);
      chk("basic_busy_idle", int'(busy1), 0);

      // wrap-around
      launch(1, 8'hFF, 8'h01, 1'b0);
      wait_done(lat, bc);
      chk("wrap_res_hex", int'(res1), 8'h00);
      check_result("wrap", 8'hFF, 8'h01, 1'b0, lat, 9);
      tick();

      // signed overflow with carry-in
      launch(1, 8'h7F, 8'h00, 1'b1);
      wait_done(lat, bc);
      chk("ovf_res_hex", int'(res1), 8'h80);
      check_result("ovf", 8'h7F, 8'h00, 1'b1, lat, 9);
      tick();

      // START during RUN is ignored
      launch(1, 8'h20, 8'h03, 1'b0);
      tick(); tick();
      A = 8'h55; B = 8'h55; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      wait_done(lat, bc);
      check_result("ignore", 8'h20, 8'h03, 1'b0, lat + 3, 9);
      tick();

      // back-to-back start in the FIN cycle
      launch(1, 8'h10, 8'h20, 1'b0);
      wait_done(lat, bc);
      chk("b2b_first_res", int'(res1), 8'h30);
      launch(1, 8'h01, 8'h01, 1'b0);
      chk("b2b_res_cleared", int'(res1), 0);
      chk("b2b_done_low", int'(done1), 0);
      wait_done(lat, bc);
      check_result("b2b", 8'h01, 8'h01, 1'b0, lat, 9);
      tick();

      // reset in the 4th RUN cycle
      launch(1, 8'h33, 8'h44, 1'b0);
      tick(); tick(); tick();
      chk("abort_partial_res", int'(res1), 8'hE0);
      RST = 1'b1;
      #1;
      chk("abort_busy", int'(busy1), 0);
      chk("abort_res",  int'(res1),  0);
      chk("abort_done", int'(done1), 0);
      tick(); tick();
      RST = 1'b0;
      bc = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (done1 || busy1) bc++;
      end
      chk("abort_no_done", bc, 0);
      launch(1, 8'h0A, 8'h05, 1'b0);
      wait_done(lat, bc);
      chk("fresh_res_hex", int'(res1), 8'h0F);
      check_result("fresh", 8'h0A, 8'h05, 1'b0, lat, 9);
      tick();

      // DIGIT=4 and DIGIT=8 sweep, including fixed corner operands
      for (int k = 0; k < 6; k++) begin
         if (k == 0) begin
            ra = 8'hFF; rb = 8'h01; rc = 1'b0;
         end else if (k == 1) begin
            ra = 8'h7F; rb = 8'h00; rc = 1'b1;
         end else begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
         end
         launch(4, ra, rb, rc);
         wait_done(lat, bc);
         check_result("d4", ra, rb, rc, lat, 3);
         tick();
         launch(8, ra, rb, rc);
         wait_done(lat, bc);
         check_result("d8", ra, rb, rc, lat, 2);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
